boot_overlay_ctl: RTL and testbench

Sequencer and read-path arbiter for the boot ROM overlay. It holds the CPU in reset after power-up and maps the ROM page 07400–07577 over RAM while the boot code runs. On the fetch of the exit address it retires the overlay after a fixed drain window. It also steers each CPU read to ROM or RAM and returns the data one cycle later; the front panel can re-arm the whole sequence.

---
 rtl/boot_pkg.sv | 28 ++
 rtl/boot_delay_cnt.sv | 30 +++
 rtl/boot_overlay_ctl.sv | 123 ++++++++++++
 tb/tb_boot_overlay_ctl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot ROM overlay sequencer.
package boot_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    OVERLAY = 2'd1,
    DRAIN   = 2'd2,
    OFF     = 2'd3
  } boot_state_e;

  localparam logic [14:0] ROM_BASE_DEF     = 15'o07400;
  localparam logic [14:0] ROM_LIMIT_DEF    = 15'o07577;
  localparam logic [14:0] EXIT_ADDR_DEF    = 15'o07415;
  localparam int unsigned HOLD_CYCLES_DEF  = 4;
  localparam int unsigned DRAIN_CYCLES_DEF = 6;

  // The counter only ever holds N-1, so $clog2(N) bits are enough.
  function automatic int cnt_width(input int unsigned hold, input int unsigned drain);
    int unsigned m;
    int          w;
    m = (hold > drain) ? hold : drain;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W_DEF = cnt_width(HOLD_CYCLES_DEF, DRAIN_CYCLES_DEF);

endpackage

// File: rtl/boot_delay_cnt.sv
// Loadable down-counter with zero flag, shared by the HOLD and DRAIN phases.
module boot_delay_cnt #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/boot_overlay_ctl.sv
// Boot ROM overlay sequencer: holds the CPU, maps the ROM window, retires it
// after the exit fetch, and steers CPU reads to ROM or RAM with 1-cycle latency.
module boot_overlay_ctl
  import boot_pkg::*;
#(
  parameter logic [14:0] ROM_BASE     = ROM_BASE_DEF,
  parameter logic [14:0] ROM_LIMIT    = ROM_LIMIT_DEF,
  parameter logic [14:0] EXIT_ADDR    = EXIT_ADDR_DEF,
  parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        boot_req,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [11:0] rom_data,
  input  logic [11:0] ram_data,
  output logic        rom_rd,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [11:0] cpu_data,
  output logic        cpu_rd_valid,
  output logic        cpu_hold,
  output logic        overlay_active
);

  localparam int           CNT_W    = cnt_width(HOLD_CYCLES, DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

  boot_state_e      r_state;
  boot_state_e      w_state_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic             w_rd_req;
  logic             w_in_win;
  logic             w_rom_sel;
  logic             w_exit;
  logic             r_rd_valid;
  logic [11:0]      r_cpu_data;

  // A simultaneous write suppresses the read entirely.
  assign w_rd_req  = cpu_rd & ~cpu_wr;
  assign w_in_win  = (cpu_addr >= ROM_BASE) && (cpu_addr <= ROM_LIMIT);
  assign w_exit    = w_rd_req && (cpu_addr == EXIT_ADDR);
  assign w_rom_sel = overlay_active & w_in_win;

  assign rom_rd = w_rd_req &  w_rom_sel;
  assign ram_rd = w_rd_req & ~w_rom_sel;
  assign ram_wr = cpu_wr;

  assign cpu_hold       = (r_state == HOLD);
  assign overlay_active = (r_state != OFF);
  assign cpu_data       = r_cpu_data;
  assign cpu_rd_valid   = r_rd_valid;

  boot_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_delay_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HOLD;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = HOLD_LD;
    w_dec       = 1'b0;
    if (boot_req) begin
      w_state_nxt = HOLD;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_zero) w_state_nxt = OVERLAY;
          else        w_dec       = 1'b1;
        end
        OVERLAY: begin
          if (w_exit) begin
            w_state_nxt = DRAIN;
            w_load      = 1'b1;
            w_load_val  = DRAIN_LD;
          end
        end
        DRAIN: begin
          if (w_zero) w_state_nxt = OFF;
          else        w_dec       = 1'b1;
        end
        default: w_state_nxt = OFF;
      endcase
    end
  end

  // Source is chosen from the request-cycle state, so a read on the edge
  // that retires the overlay still captures ROM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_cpu_data <= '0;
    end else begin
      r_rd_valid <= w_rd_req;
      if (rom_rd)      r_cpu_data <= rom_data;
      else if (ram_rd) r_cpu_data <= ram_data;
    end
  end

endmodule

// File: tb/tb_boot_overlay_ctl.sv
// Directed self-checking bench for boot_overlay_ctl.
module tb_boot_overlay_ctl;

  logic        clk;
  logic        reset_n;
  logic        boot_req;
  logic [14:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [11:0] rom_data;
  logic [11:0] ram_data;
  logic        rom_rd;
  logic        ram_rd;
  logic        ram_wr;
  logic [11:0] cpu_data;
  logic        cpu_rd_valid;
  logic        cpu_hold;
  logic        overlay_active;

  int n_vec;
  int n_err;

  boot_overlay_ctl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .boot_req       (boot_req),
    .cpu_addr       (cpu_addr),
    .cpu_rd         (cpu_rd),
    .cpu_wr         (cpu_wr),
    .rom_data       (rom_data),
    .ram_data       (ram_data),
    .rom_rd         (rom_rd),
    .ram_rd         (ram_rd),
    .ram_wr         (ram_wr),
    .cpu_data       (cpu_data),
    .cpu_rd_valid   (cpu_rd_valid),
    .cpu_hold       (cpu_hold),
    .overlay_active (overlay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    boot_req = 1'b0;
  endtask

  // Expects to be called right after the edge that entered HOLD.
  task automatic check_hold_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_hold_hi"}, 32'(cpu_hold), 32'd1);
      step();
    end
    check({tag, "_hold_lo"}, 32'(cpu_hold), 32'd0);
    check({tag, "_ovl_on"}, 32'(overlay_active), 32'd1);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    cpu_addr = '0;
    rom_data = '0;
    ram_data = '0;
    idle();

    #1;
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ovl", 32'(overlay_active), 32'd1);
    check("rst_data", 32'(cpu_data), 32'd0);
    check("rst_valid", 32'(cpu_rd_valid), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("por_hold_hi", 32'(cpu_hold), 32'd1);
      step();
    end
    check("por_hold_lo", 32'(cpu_hold), 32'd0);
    check("por_ovl_on", 32'(overlay_active), 32'd1);

    // In-window read served by ROM.
    cpu_addr = 15'o07400; cpu_rd = 1'b1; rom_data = 12'o7240; ram_data = 12'o0000;
    #1;
    check("rd_win_rom_rd", 32'(rom_rd), 32'd1);
    check("rd_win_ram_rd", 32'(ram_rd), 32'd0);
    step();
    idle();
    check("rd_win_valid", 32'(cpu_rd_valid), 32'd1);
    check("rd_win_data", 32'(cpu_data), 32'o7240);

    // Out-of-window read goes to RAM even with the overlay mapped.
    cpu_addr = 15'o00100; cpu_rd = 1'b1; ram_data = 12'o1357;
    #1;
    check("rd_low_rom_rd", 32'(rom_rd), 32'd0);
    check("rd_low_ram_rd", 32'(ram_rd), 32'd1);
    step();
    idle();
    check("rd_low_data", 32'(cpu_data), 32'o1357);

    // In-window write with overlay on goes to RAM.
    cpu_addr = 15'o07410; cpu_wr = 1'b1;
    #1;
    check("wr_ram_wr", 32'(ram_wr), 32'd1);
    check("wr_rom_rd", 32'(rom_rd), 32'd0);
    check("wr_ram_rd", 32'(ram_rd), 32'd0);
    step();
    idle();

    // Illegal read+write: write only, no valid afterwards.
    cpu_addr = 15'o07400; cpu_rd = 1'b1; cpu_wr = 1'b1;
    #1;
    check("rdwr_rom_rd", 32'(rom_rd), 32'd0);
    check("rdwr_ram_rd", 32'(ram_rd), 32'd0);
    check("rdwr_ram_wr", 32'(ram_wr), 32'd1);
    step();
    idle();
    check("rdwr_valid", 32'(cpu_rd_valid), 32'd0);

    // Exit read, then back-to-back in-window reads across the drain window.
    rom_data = 12'o1111; ram_data = 12'o2222;
    cpu_addr = 15'o07415; cpu_rd = 1'b1;
    #1;
    check("exit_rom_rd", 32'(rom_rd), 32'd1);
    step();
    check("exit_data", 32'(cpu_data), 32'o1111);
    cpu_addr = 15'o07400;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check("drain_rom_rd", 32'(rom_rd), (k <= 6) ? 32'd1 : 32'd0);
      step();
      check("drain_valid", 32'(cpu_rd_valid), 32'd1);
      check("drain_data", 32'(cpu_data), (k <= 6) ? 32'o1111 : 32'o2222);
      check("drain_ovl", 32'(overlay_active), (k < 6) ? 32'd1 : 32'd0);
    end
    idle();

    // After retirement the previously written address reads from RAM.
    cpu_addr = 15'o07410; cpu_rd = 1'b1; ram_data = 12'o3333;
    #1;
    check("off_rom_rd", 32'(rom_rd), 32'd0);
    check("off_ram_rd", 32'(ram_rd), 32'd1);
    step();
    idle();
    check("off_data", 32'(cpu_data), 32'o3333);
    check("off_hold", 32'(cpu_hold), 32'd0);

    // Re-arm from OFF.
    boot_req = 1'b1;
    step();
    idle();
    check_hold_seq("rearm_off");

    // Re-arm beats a simultaneous exit read: no drain follows.
    cpu_addr = 15'o07415; cpu_rd = 1'b1; boot_req = 1'b1;
    step();
    idle();
    check_hold_seq("rearm_exit");
    for (int i = 0; i < 4; i++) step();
    check("rearm_exit_no_drain", 32'(overlay_active), 32'd1);

    // Reset asserted the cycle after a read kills the valid at once.
    cpu_addr = 15'o07500; cpu_rd = 1'b1; rom_data = 12'o4321;
    step();
    idle();
    check("mid_rd_valid", 32'(cpu_rd_valid), 32'd1);
    check("mid_rd_data", 32'(cpu_data), 32'o4321);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(cpu_rd_valid), 32'd0);
    check("async_rst_data", 32'(cpu_data), 32'd0);
    check("async_rst_hold", 32'(cpu_hold), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
